// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end. Owns the fetch PC,
// issues credit-limited word requests to instruction memory, buffers the
// in-order responses with their PCs, and hands them to decode. A redirect
// flushes the buffer and drops every response still in flight.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     inst_valid,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q,    fetch_pc_d;
  logic [31:0]   rsp_pc_q,      rsp_pc_d;
  logic [CW-1:0] count_q,       count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q,    drop_cnt_d;
  logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic [CW:0]   credit_sum;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Request channel, head-of-queue outputs and handshake qualifiers
  always_comb begin
    credit_sum      = {1'b0, outstanding_q} + {1'b0, count_q};
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
    // A slot is reserved for every request, so responses never overflow.
    imem_req_valid  = !rst && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
    imem_req_addr   = fetch_pc_q;
    req_fire        = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding (e.g. straight after reset) are ignored.
    rsp_accept      = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop        = rsp_accept && ((drop_cnt_q != '0) || redirect_valid);
    inst_valid      = (count_q != '0);
    inst_pc         = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;
    inst            = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
    occupancy       = count_q;
    push            = rsp_accept && !rsp_drop;
    pop             = inst_valid && inst_ready && !redirect_valid;
  end

  // Next-state for PCs, counters and FIFO pointers; redirect has priority
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    case ({req_fire, rsp_accept})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still in flight belongs to the old path; the response
      // landing this cycle is already dropped, so it is not counted again.
      drop_cnt_d = rsp_accept ? (outstanding_q - CW'(1)) : outstanding_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage write port
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]   = rsp_pc_q;
      inst_mem_d[wr_ptr_q] = imem_rsp_data;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
    end
  end

  a_rsp_with_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding_q != '0));

  a_credit_limit: assert property (
    @(posedge clk) disable iff (rst) credit_sum <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order variable-latency memory.
module tb_fetch_queue;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_ready;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst),
    .inst_ready(inst_ready), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: in-order, mem_lat cycles from handshake to sampled response
  logic [31:0] addr_q[$];
  int          due_q[$];
  int          mcyc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q.delete();
      due_q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      mcyc           <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        addr_q.push_back(imem_req_addr);
        due_q.push_back(mcyc + mem_lat - 1);
      end
      if (due_q.size() > 0 && due_q[0] <= mcyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= addr_q[0] ^ XORK;
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= '0;
      end
      mcyc <= mcyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Returns at the negedge where rst drops (cycle 0)
  task automatic do_reset(input int lat, input logic ir);
    cyc();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = ir;
    mem_lat        = lat;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    cyc();
    cyc();
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", imem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      #1;
      if (k == 1) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got inst_valid=%b want 0 at cycle 1", inst_valid); end
      end else begin
        logic [31:0] ep;
        ep = 32'(4 * (k - 2));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== (ep ^ XORK)) begin
          errors++; $display("FAIL stream_k%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, ep, ep ^ XORK);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset(1, 1'b0);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) cyc();
      #1;
      if (imem_req_valid && imem_req_ready) nreq++;
    end
    checks++; if (nreq !== 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", nreq); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy got %0d want 4", occupancy); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked got %b want 0", imem_req_valid); end
    for (int k = 0; k <= 7; k++) begin
      logic [31:0] ep;
      cyc();
      inst_ready = 1'b1;
      #1;
      ep = 32'(4 * k);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== (ep ^ XORK)) begin
        errors++; $display("FAIL bp_drain_k%0d got v=%b pc=%h inst=%h want v=1 pc=%h", k, inst_valid, inst_pc, inst, ep);
      end
      if (k == 1) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(3, 1'b1);
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b want 0", imem_req_valid); end
    for (int k = 3; k <= 8; k++) begin
      cyc();
      redirect_valid = 1'b0;
      #1;
      if (k == 3) begin
        checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want 100", imem_req_addr); end
      end
      if (k <= 6) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_k%0d got inst_valid=%b pc=%h want 0", k, inst_valid, inst_pc); end
      end else begin
        logic [31:0] ep;
        ep = (k == 7) ? 32'h100 : 32'h104;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== (ep ^ XORK)) begin
          errors++; $display("FAIL redir_new_k%0d got v=%b pc=%h inst=%h want pc=%h", k, inst_valid, inst_pc, inst, ep);
        end
      end
    end
  endtask

  task automatic test_redirect_collision();
    do_reset(2, 1'b1);
    cyc();
    cyc();
    cyc();
    #1;
    checks++; if (inst_valid !== 1'b1 || occupancy !== 3'd1) begin errors++; $display("FAIL coll_pre got v=%b occ=%0d want v=1 occ=1", inst_valid, occupancy); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    for (int k = 4; k <= 8; k++) begin
      cyc();
      redirect_valid = 1'b0;
      #1;
      if (k == 4) begin
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL coll_flush got occ=%0d want 0", occupancy); end
      end
      if (k <= 6) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_stale_k%0d got inst_valid=%b pc=%h want 0", k, inst_valid, inst_pc); end
      end else begin
        logic [31:0] ep;
        ep = (k == 7) ? 32'h200 : 32'h204;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== (ep ^ XORK)) begin
          errors++; $display("FAIL coll_new_k%0d got v=%b pc=%h inst=%h want pc=%h", k, inst_valid, inst_pc, inst, ep);
        end
      end
    end
  endtask

  task automatic test_req_stall();
    do_reset(1, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 2) imem_req_ready = 1'b0;
      if (k == 7) imem_req_ready = 1'b1;
      #1;
      if (k >= 2 && k <= 7) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL stall_req_k%0d got v=%b a=%h want v=1 a=8", k, imem_req_valid, imem_req_addr); end
      end
      if (k >= 4 && k <= 8) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_gap_k%0d got inst_valid=%b want 0", k, inst_valid); end
      end
      if (k >= 9) begin
        logic [31:0] ep;
        ep = 32'(8 + 4 * (k - 9));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== ep || inst !== (ep ^ XORK)) begin
          errors++; $display("FAIL stall_seq_k%0d got v=%b pc=%h inst=%h want pc=%h", k, inst_valid, inst_pc, inst, ep);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1, 1'b0);
    for (int k = 1; k <= 4; k++) cyc();
    #1;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL areset_pre got occ=%0d want 3", occupancy); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL areset_inst_valid got %b want 0", inst_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL areset_occupancy got %0d want 0", occupancy); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid got %b want 0", imem_req_valid); end
    cyc();
    cyc();
    rst = 1'b0;
    inst_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL areset_restart got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    cyc();
    cyc();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== XORK) begin errors++; $display("FAIL areset_first got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", inst_valid, inst_pc, inst, XORK); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_req_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
